// File: rtl/output_port_unit.sv
// Router egress stage: buffers incoming flits and forwards complete packets
// downstream over a req/ack handshake, one flit per cycle once granted.
module output_port_unit #(
  parameter int FLIT_W      = 32,
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [FLIT_W-1:0]        i_flit,
  output logic                     o_flit_ready,
  output logic [FLIT_W-1:0]        o_flit,
  output logic                     o_transmit_req,
  input  logic                     i_transmit_ack,
  output logic                     o_busy,
  output logic                     o_retry,
  output logic [$clog2(DEPTH):0]   o_pkt_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_t;

  state_t            state_reg, state_next;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]       count_reg, pkt_cnt_reg;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [FLIT_W-1:0] flit_reg, flit_next;
  logic              req_reg, req_next;
  logic              retry_reg, retry_next;
  logic              full, empty, push, pop, push_tail, pop_tail;
  logic [FLIT_W-1:0] head;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign head      = mem[rd_ptr_reg];
  assign push      = i_flit[FLIT_W-1] && !full;
  assign push_tail = push && (i_flit[FLIT_W-2 -: 2] == TYPE_TAIL);
  assign pop_tail  = pop && (head[FLIT_W-2 -: 2] == TYPE_TAIL);

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= i_flit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      pkt_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      case ({push_tail, pop_tail})
        2'b10:   pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
        2'b01:   pkt_cnt_reg <= pkt_cnt_reg - 1'b1;
        default: pkt_cnt_reg <= pkt_cnt_reg;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    req_next   = req_reg;
    retry_next = 1'b0;
    flit_next  = '0;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pkt_cnt_reg != '0) begin
          state_next = REQ;
          req_next   = 1'b1;
          timer_next = '0;
        end
      end
      REQ: begin
        // A grant arriving on the timeout cycle still wins.
        if (i_transmit_ack) begin
          state_next = SEND;
          req_next   = 1'b0;
        end else if (timer_reg == TW'(ACK_TIMEOUT - 1)) begin
          state_next = WAIT;
          req_next   = 1'b0;
          retry_next = 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT: begin
        state_next = REQ;
        req_next   = 1'b1;
        timer_next = '0;
      end
      SEND: begin
        if (!empty) begin
          pop       = 1'b1;
          flit_next = {1'b1, head[FLIT_W-2:0]};
          if (head[FLIT_W-2 -: 2] == TYPE_TAIL) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      req_reg   <= 1'b0;
      retry_reg <= 1'b0;
      flit_reg  <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      req_reg   <= req_next;
      retry_reg <= retry_next;
      flit_reg  <= flit_next;
    end
  end

  assign o_flit_ready   = ~full;
  assign o_flit         = flit_reg;
  assign o_transmit_req = req_reg;
  assign o_retry        = retry_reg;
  assign o_busy         = (state_reg != IDLE);
  assign o_pkt_cnt      = pkt_cnt_reg;
endmodule

// File: tb/tb_output_port_unit.sv
// Self-checking bench for output_port_unit: table vectors, corner-case
// sequences and random traffic against a packet-queue reference model.
module tb_output_port_unit;
  localparam int FLIT_W = 32;
  localparam int DEPTH = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] T_HEAD = 2'b01, T_BODY = 2'b10, T_TAIL = 2'b11, T_RSV = 2'b00;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [FLIT_W-1:0] i_flit = '0;
  logic              i_transmit_ack = 1'b0;
  logic              o_flit_ready, o_transmit_req, o_busy, o_retry;
  logic [FLIT_W-1:0] o_flit;
  logic [CW-1:0]     o_pkt_cnt;

  always #5 clk = ~clk;

  output_port_unit #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .i_flit(i_flit), .o_flit_ready(o_flit_ready),
    .o_flit(o_flit), .o_transmit_req(o_transmit_req), .i_transmit_ack(i_transmit_ack),
    .o_busy(o_busy), .o_retry(o_retry), .o_pkt_cnt(o_pkt_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: flits accepted but not yet seen on o_flit, plus handshake history.
  logic [FLIT_W-1:0] q[$];
  logic [FLIT_W-1:0] src[$];
  logic [FLIT_W-1:0] last_out = '0;
  int req_run = 0;
  bit acked_prev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [28:0] p);
    return {1'b1, t, p};
  endfunction

  function automatic int tails_in_q();
    int n = 0;
    foreach (q[i]) if (q[i][FLIT_W-2 -: 2] == T_TAIL) n++;
    return n;
  endfunction

  // One clock: inputs are held across the posedge, outputs sampled at the following negedge.
  task automatic tick();
    logic ready_b, req_b, ack_b, exp_start;
    logic [FLIT_W-1:0] flit_b;
    int run_b;
    ready_b = o_flit_ready; req_b = o_transmit_req; ack_b = i_transmit_ack;
    flit_b = i_flit; run_b = req_run;
    @(posedge clk);
    @(negedge clk);
    if (!reset_n) begin
      q.delete(); last_out = '0; req_run = 0; acked_prev = 0;
      chk("rst_flit", o_flit, 0);
      chk("rst_req", o_transmit_req, 0);
      chk("rst_retry", o_retry, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_pkt_cnt", o_pkt_cnt, 0);
      chk("rst_ready", o_flit_ready, 1);
      return;
    end
    exp_start = acked_prev;
    acked_prev = ack_b && req_b;
    if (exp_start) chk("ack_latency", o_flit != 0, 1);
    if (o_flit != 0) begin
      if (last_out == 0) chk("start_without_ack", exp_start, 1);
      if (last_out[FLIT_W-2 -: 2] == T_TAIL) chk("gap_after_tail", o_flit, 0);
      if (q.size() == 0) chk("pop_from_empty", o_flit, 0);
      else begin
        chk("flit_data", o_flit, {1'b1, q[0][FLIT_W-2:0]});
        void'(q.pop_front());
      end
    end else if (last_out != 0 && last_out[FLIT_W-2 -: 2] != T_TAIL) begin
      chk("bubble_in_packet", 0, 1);
    end
    if (flit_b[FLIT_W-1] && ready_b) q.push_back(flit_b);
    chk("pkt_cnt", o_pkt_cnt, tails_in_q());
    chk("ready", o_flit_ready, q.size() < DEPTH);
    chk("retry", o_retry, (run_b == ACK_TIMEOUT) && !(ack_b && req_b));
    req_run = o_transmit_req ? req_run + 1 : 0;
    if (req_run > ACK_TIMEOUT) chk("req_too_long", req_run, ACK_TIMEOUT);
    last_out = o_flit;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; i_flit = '0; i_transmit_ack = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push_flit(input logic [FLIT_W-1:0] f);
    i_flit = f;
    tick();
    i_flit = '0;
  endtask

  // Source offers src[] (holding while not ready); downstream acks with random delay.
  task automatic run(input int cycles, input int max_delay, input bit noise);
    bit accepted;
    for (int c = 0; c < cycles; c++) begin
      i_flit = (src.size() > 0 && $urandom_range(0, 3) != 0) ? src[0] : '0;
      if (o_transmit_req) i_transmit_ack = ($urandom_range(0, max_delay) == 0);
      else i_transmit_ack = noise && ($urandom_range(0, 9) == 0);
      accepted = i_flit[FLIT_W-1] && o_flit_ready;
      tick();
      if (accepted) void'(src.pop_front());
    end
    i_flit = '0; i_transmit_ack = 1'b0;
  endtask

  task automatic gen_pkt(input int len);
    src.push_back(mk(T_HEAD, 29'($urandom)));
    for (int k = 1; k < len - 1; k++)
      src.push_back(mk(($urandom_range(0, 3) == 0) ? T_RSV : T_BODY, 29'($urandom)));
    src.push_back(mk(T_TAIL, 29'($urandom)));
  endtask

  typedef struct {
    logic [FLIT_W-1:0] flit;
    logic [CW-1:0]     cnt;
    logic              rdy;
    logic              req;
  } vec_t;
  vec_t vecs[11];

  initial begin
    logic [FLIT_W-1:0] p1 [4];

    // Ingress table, ack held low: invalid flits, reserved type, fill and drop while full.
    vecs[0]  = '{mk(T_HEAD, 29'h11), 0, 1, 0};
    vecs[1]  = '{mk(T_BODY, 29'h12), 0, 1, 0};
    vecs[2]  = '{{1'b0, T_TAIL, 29'h13}, 0, 1, 0};
    vecs[3]  = '{mk(T_RSV, 29'h14), 0, 1, 0};
    vecs[4]  = '{mk(T_TAIL, 29'h15), 1, 1, 0};
    vecs[5]  = '{mk(T_HEAD, 29'h21), 1, 1, 1};
    vecs[6]  = '{mk(T_BODY, 29'h22), 1, 1, 1};
    vecs[7]  = '{mk(T_BODY, 29'h23), 1, 1, 1};
    vecs[8]  = '{mk(T_TAIL, 29'h24), 2, 0, 1};
    vecs[9]  = '{mk(T_TAIL, 29'h99), 2, 0, 1};
    vecs[10] = '{32'h0, 2, 0, 1};

    do_reset();

    // Test 1: single 4-flit packet, request timing and ack-to-data latency.
    p1[0] = mk(T_HEAD, 29'h1a1); p1[1] = mk(T_BODY, 29'h1a2);
    p1[2] = mk(T_BODY, 29'h1a3); p1[3] = mk(T_TAIL, 29'h1a4);
    for (int k = 0; k < 4; k++) push_flit(p1[k]);
    chk("t1_req_early", o_transmit_req, 0);
    tick();
    chk("t1_req_rise", o_transmit_req, 1);
    chk("t1_busy", o_busy, 1);
    tick(); tick();
    i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
    chk("t1_req_drop", o_transmit_req, 0);
    chk("t1_flit_before", o_flit, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_flit", o_flit, p1[k]);
    end
    tick();
    chk("t1_flit_after", o_flit, 0);
    chk("t1_pkt_cnt", o_pkt_cnt, 0);

    // Test 2: head+body without tail never requests.
    do_reset();
    push_flit(mk(T_HEAD, 29'h2)); push_flit(mk(T_BODY, 29'h3));
    for (int k = 0; k < 100; k++) begin
      tick();
      if (k % 25 == 0) chk("t2_no_req", o_transmit_req, 0);
    end

    // Test 3: ack withheld -> 16 req cycles, retry pulse, one low cycle, then success.
    do_reset();
    push_flit(mk(T_HEAD, 29'h31)); push_flit(mk(T_TAIL, 29'h32));
    tick();
    for (int k = 0; k < ACK_TIMEOUT; k++) begin
      chk("t3_req_hold", o_transmit_req, 1);
      tick();
    end
    chk("t3_req_low", o_transmit_req, 0);
    chk("t3_retry", o_retry, 1);
    tick();
    chk("t3_req_again", o_transmit_req, 1);
    chk("t3_retry_once", o_retry, 0);
    i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
    tick(); chk("t3_head", o_flit, mk(T_HEAD, 29'h31));
    tick(); chk("t3_tail", o_flit, mk(T_TAIL, 29'h32));
    tick(); chk("t3_done", o_flit, 0);

    // Test 4: table-driven fill to full, then drain while a 2-flit packet arrives.
    do_reset();
    foreach (vecs[i]) begin
      i_flit = vecs[i].flit;
      tick();
      chk($sformatf("vec%0d_cnt", i), o_pkt_cnt, vecs[i].cnt);
      chk($sformatf("vec%0d_rdy", i), o_flit_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_req", i), o_transmit_req, vecs[i].req);
    end
    i_flit = '0;
    src.push_back(mk(T_HEAD, 29'h41)); src.push_back(mk(T_TAIL, 29'h42));
    run(80, 0, 0);
    chk("t4_src_done", src.size(), 0);
    chk("t4_drained", q.size(), 0);

    // Test 5: two back-to-back 2-flit packets need two separate sessions.
    do_reset();
    push_flit(mk(T_HEAD, 29'h51)); push_flit(mk(T_TAIL, 29'h52));
    push_flit(mk(T_HEAD, 29'h53)); push_flit(mk(T_TAIL, 29'h54));
    chk("t5_cnt2", o_pkt_cnt, 2);
    i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
    tick(); tick();
    chk("t5_cnt1", o_pkt_cnt, 1);
    chk("t5_req_gap", o_transmit_req, 0);
    tick();
    chk("t5_req2", o_transmit_req, 1);
    i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
    tick(); tick(); tick();
    chk("t5_cnt0", o_pkt_cnt, 0);

    // Test 6: reset mid-SEND abandons the packet and empties the FIFO.
    do_reset();
    for (int k = 0; k < 4; k++) push_flit(p1[k]);
    tick();
    i_transmit_ack = 1'b1; tick(); i_transmit_ack = 1'b0;
    tick(); tick();
    chk("t6_mid_send", o_flit, p1[1]);
    do_reset();
    src.push_back(mk(T_HEAD, 29'h61)); src.push_back(mk(T_TAIL, 29'h62));
    run(30, 0, 0);
    chk("t6_drained", q.size(), 0);

    // Random traffic with random ack delays (some retries) and stray acks.
    do_reset();
    for (int n = 0; n < 120; n++) gen_pkt($urandom_range(2, DEPTH));
    run(4000, 8, 1);
    run(1000, 0, 0);
    chk("rnd_src_done", src.size(), 0);
    chk("rnd_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
